// File: rtl/collector_pkg.sv
// Shared types and constants for the mesh result collector tile.
// Status bit positions are given for the default 32-bit stream width.
package collector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_REP_SUM,
    ST_REP_CNT,
    ST_DONE
  } coll_state_t;

  localparam int unsigned REP_BEAT_SUM = 0;
  localparam int unsigned REP_BEAT_CNT = 1;

  localparam int unsigned DEF_TDATAW = 32;
  localparam int unsigned ERR_TO_BIT = DEF_TDATAW - 1;
  localparam int unsigned ERR_FR_BIT = DEF_TDATAW - 2;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered AXIS master stage: outputs come straight from flops and
// the held entry stays stable until the sink accepts it.
module axis_reg_slice #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DATAW-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DATAW-1:0] out_data_o,
  output logic             out_last_o
);

  logic             valid_q;
  logic             last_q;
  logic [DATAW-1:0] data_q;

  // The slot can take a new entry when empty or when its entry leaves this cycle.
  assign in_ready_o = ~valid_q | out_ready_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      last_q  <= in_last_i;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/axis_result_collector.sv
// Mesh consumer tile: counts result packets, sums their beats, and sends a
// two-beat report (checksum, then status) once the run completes or stalls.
module axis_result_collector
  import collector_pkg::*;
#(
  parameter int          TDATAW         = 32,
  parameter int          TDESTW         = 4,
  parameter int          NUM_PACKETS    = 8,
  parameter int          MAX_BEATS      = 16,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [TDESTW-1:0] REPORT_DEST = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
  output logic              DONE,
  output logic              ERR_FRAMING,
  output logic              ERR_TIMEOUT,
  output logic [TDATAW-1:0] PKT_COUNT,
  output logic [TDATAW-1:0] CHECKSUM
);

  // Status flags sit at fixed offsets from the MSB whatever the width.
  localparam int ToBit = TDATAW - DEF_TDATAW + ERR_TO_BIT;
  localparam int FrBit = TDATAW - DEF_TDATAW + ERR_FR_BIT;

  localparam logic [TDATAW-1:0] One     = TDATAW'(1);
  localparam logic [TDATAW-1:0] BeatLim = TDATAW'(MAX_BEATS - 1);
  localparam logic [TDATAW-1:0] IdleLim = TDATAW'(TIMEOUT_CYCLES - 1);
  localparam logic [TDATAW-1:0] PktLim  = TDATAW'(NUM_PACKETS);

  coll_state_t       state_q;
  logic              tready_q;
  logic              done_q;
  logic              err_fr_q;
  logic              err_to_q;
  logic [TDATAW-1:0] pkt_q;
  logic [TDATAW-1:0] sum_q;
  logic [TDATAW-1:0] beat_q;
  logic [TDATAW-1:0] idle_q;

  logic              s_hs;
  logic              m_hs;
  logic [TDATAW-1:0] sum_d;
  logic [TDATAW-1:0] pkt_d;
  logic              last_pkt;
  logic              timeout;
  logic              finish;
  logic [TDATAW-1:0] status_word;
  int unsigned       rep_beat;

  logic              rs_in_valid;
  logic              rs_in_ready;
  logic [TDATAW-1:0] rs_in_data;
  logic              rs_in_last;

  logic              unused_tdest;
  assign unused_tdest = ^AXIS_S_TDEST;

  // TREADY is only ever high in COLLECT, so it doubles as the state qualifier.
  assign s_hs     = AXIS_S_TVALID & tready_q;
  assign m_hs     = AXIS_M_TVALID & AXIS_M_TREADY;
  assign sum_d    = s_hs ? (sum_q + AXIS_S_TDATA) : sum_q;
  assign pkt_d    = pkt_q + One;
  assign last_pkt = s_hs & AXIS_S_TLAST & (pkt_d == PktLim);
  assign timeout  = (state_q == ST_COLLECT) & ~s_hs & (idle_q == IdleLim);
  assign finish   = last_pkt | timeout;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    status_word        = pkt_q;
    status_word[ToBit] = err_to_q;
    status_word[FrBit] = err_fr_q;
  end

  // The sum beat is loaded on the collect exit edge for one-cycle latency; the
  // status beat replaces it as soon as the sum beat is taken.
  assign rep_beat    = (state_q == ST_REP_SUM) ? REP_BEAT_CNT : REP_BEAT_SUM;
  assign rs_in_valid = finish | (state_q == ST_REP_SUM);
  assign rs_in_data  = (rep_beat == REP_BEAT_CNT) ? status_word : sum_d;
  assign rs_in_last  = (rep_beat == REP_BEAT_CNT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      tready_q <= 1'b0;
      done_q   <= 1'b0;
      err_fr_q <= 1'b0;
      err_to_q <= 1'b0;
      pkt_q    <= '0;
      sum_q    <= '0;
      beat_q   <= '0;
      idle_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state_q  <= ST_COLLECT;
            tready_q <= 1'b1;
            done_q   <= 1'b0;
            err_fr_q <= 1'b0;
            err_to_q <= 1'b0;
            pkt_q    <= '0;
            sum_q    <= '0;
            beat_q   <= '0;
            idle_q   <= '0;
          end
        end
        ST_COLLECT: begin
          if (s_hs) begin
            sum_q  <= sum_d;
            idle_q <= '0;
            if (AXIS_S_TLAST) begin
              beat_q <= '0;
              pkt_q  <= pkt_d;
            end else if (beat_q == BeatLim) begin
              err_fr_q <= 1'b1;
            end else begin
              beat_q <= beat_q + One;
            end
          end else if (timeout) begin
            err_to_q <= 1'b1;
          end else begin
            idle_q <= idle_q + One;
          end
          if (finish) begin
            tready_q <= 1'b0;
            state_q  <= ST_REP_SUM;
          end
        end
        ST_REP_SUM: begin
          if (rs_in_ready) state_q <= ST_REP_CNT;
        end
        ST_REP_CNT: begin
          if (m_hs) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  axis_reg_slice #(
    .DATAW(TDATAW)
  ) u_report_slice (
    .clk        (CLK),
    .rst        (RST),
    .in_valid_i (rs_in_valid),
    .in_ready_o (rs_in_ready),
    .in_data_i  (rs_in_data),
    .in_last_i  (rs_in_last),
    .out_valid_o(AXIS_M_TVALID),
    .out_ready_i(AXIS_M_TREADY),
    .out_data_o (AXIS_M_TDATA),
    .out_last_o (AXIS_M_TLAST)
  );

  assign AXIS_S_TREADY = tready_q;
  assign AXIS_M_TDEST  = REPORT_DEST;
  assign DONE          = done_q;
  assign ERR_FRAMING   = err_fr_q;
  assign ERR_TIMEOUT   = err_to_q;
  assign PKT_COUNT     = pkt_q;
  assign CHECKSUM      = sum_q;

endmodule
